// File: rtl/sleep_ctrl_pkg.sv
// Shared types and constants for the sleep/wakeup controller.
package sleep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_MATCH  = 2'b01;
  localparam logic [1:0] CAUSE_WAKEUP = 2'b10;
  localparam logic [1:0] CAUSE_ABORT  = 2'b11;

  // Highest-priority wake source wins: abort, then counter wakeup, then match.
  function automatic logic [1:0] pickCause(input logic abortIn,
                                           input logic wakeupIn,
                                           input logic matchIn);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (abortIn)       cause = CAUSE_ABORT;
    else if (wakeupIn) cause = CAUSE_WAKEUP;
    else if (matchIn)  cause = CAUSE_MATCH;
    return cause;
  endfunction

endpackage

// File: rtl/sleep_ctrl_if.sv
// Control/status bundle between the sleep controller, software and the timer counter.
interface sleep_ctrl_if #(
  parameter int CNT_W = 20
);
  logic             sleep_req;
  logic [CNT_W-1:0] sleep_cycles;
  logic             abort;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_wakeup;
  logic             cnt_en;
  logic             cnt_clr;
  logic             irq;
  logic             irq_ack;
  logic [1:0]       wake_cause;
  logic             busy;
  logic             wdog_err;

  // Environment side: software plus the counter.
  modport master (
    output sleep_req, sleep_cycles, abort, cnt_val, cnt_wakeup, irq_ack,
    input  cnt_en, cnt_clr, irq, wake_cause, busy, wdog_err
  );

  // Controller side.
  modport slave (
    input  sleep_req, sleep_cycles, abort, cnt_val, cnt_wakeup, irq_ack,
    output cnt_en, cnt_clr, irq, wake_cause, busy, wdog_err
  );
endinterface

// File: rtl/sleep_ack_wdog.sv
// Interrupt-acknowledge watchdog: counts enabled cycles, flags the ACK_TO-th.
module sleep_ack_wdog #(
  parameter int CNT_W  = 20,
  parameter int ACK_TO = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TO - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Count while enabled, restart from zero whenever the enable drops.
  always_comb begin
    count_d = en_i ? count_q + 1'b1 : '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign timeout_o = en_i && (count_q == LAST_CNT);

endmodule

// File: rtl/sleep_ctrl.sv
// Sleep/wakeup controller driving the timer counter's enable/clear and raising
// a held wake interrupt. Optional ack watchdog: define SLEEP_CTRL_WDOG_EN.
module sleep_ctrl
  import sleep_ctrl_pkg::*;
#(
  parameter int CNT_W  = 20,
  parameter int ACK_TO = 1024
) (
  input logic         clk,
  input logic         rst_n,
  sleep_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ARM   = ARM;
  localparam logic [1:0] ST_SLEEP = SLEEP;
  localparam logic [1:0] ST_WAKE  = WAKE;

  if (ACK_TO < 1) begin : gAckToCheck
    $error("ACK_TO must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [1:0]       wakeCause_q, wakeCause_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;
  logic             cntEn_q, cntEn_d;
  logic             cntClr_q, cntClr_d;
  logic             matchNow;
  logic             wakeNow;

  assign matchNow = (bus.cnt_val >= target_q);
  assign wakeNow  = bus.abort | bus.cnt_wakeup | matchNow;

`ifdef SLEEP_CTRL_WDOG_EN
  logic ackTimeout;
  logic wdogEn;
  logic wdogErr_q;

  assign wdogEn = (state_q == ST_WAKE) && !bus.irq_ack;

  sleep_ack_wdog #(
    .CNT_W (CNT_W),
    .ACK_TO(ACK_TO)
  ) uWdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (wdogEn),
    .timeout_o(ackTimeout)
  );

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)          wdogErr_q <= 1'b0;
    else if (ackTimeout) wdogErr_q <= 1'b1;
  end

  assign bus.wdog_err = wdogErr_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    wakeCause_d = wakeCause_q;
    irq_d       = irq_q;
    busy_d      = busy_q;
    cntEn_d     = cntEn_q;
    cntClr_d    = cntClr_q;
    case (state_q)
      ST_IDLE: begin
        cntEn_d  = 1'b0;
        cntClr_d = 1'b1;
        irq_d    = 1'b0;
        busy_d   = 1'b0;
        if (bus.sleep_req) begin
          target_d    = bus.sleep_cycles;
          wakeCause_d = CAUSE_NONE;
          busy_d      = 1'b1;
          state_d     = ST_ARM;
        end
      end
      ST_ARM: begin
        cntEn_d  = 1'b0;
        cntClr_d = 1'b1;
        busy_d   = 1'b1;
        state_d  = ST_SLEEP;
      end
      ST_SLEEP: begin
        cntClr_d = 1'b0;
        busy_d   = 1'b1;
        if (wakeNow) begin
          cntEn_d     = 1'b0;
          irq_d       = 1'b1;
          wakeCause_d = pickCause(bus.abort, bus.cnt_wakeup, matchNow);
          state_d     = ST_WAKE;
        end else begin
          cntEn_d = 1'b1;
        end
      end
      ST_WAKE: begin
        cntEn_d  = 1'b0;
        cntClr_d = 1'b0;
        irq_d    = 1'b1;
        busy_d   = 1'b1;
        if (bus.irq_ack) begin
          irq_d    = 1'b0;
          busy_d   = 1'b0;
          cntClr_d = 1'b1;
          state_d  = ST_IDLE;
        end
`ifdef SLEEP_CTRL_WDOG_EN
        else if (ackTimeout) begin
          irq_d    = 1'b0;
          busy_d   = 1'b0;
          cntClr_d = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      wakeCause_q <= CAUSE_NONE;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      cntEn_q     <= 1'b0;
      cntClr_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      wakeCause_q <= wakeCause_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      cntEn_q     <= cntEn_d;
      cntClr_q    <= cntClr_d;
    end
  end

  assign bus.cnt_en     = cntEn_q;
  assign bus.cnt_clr    = cntClr_q;
  assign bus.irq        = irq_q;
  assign bus.wake_cause = wakeCause_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sleep_ctrl.sv
// Directed bench for sleep_ctrl with a modelled timer counter and a wake
// scoreboard. Define SLEEP_CTRL_WDOG_EN to exercise the ack watchdog.
module tb_sleep_ctrl;

  localparam int CNT_W  = 20;
  localparam int ACK_TO = 16;

  typedef struct {
    string      tag;
    logic [1:0] cause;
    int         latency;
    int         acceptCycle;
  } sbEntry_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   cnt      = 0;
  bit   wkArm    = 0;
  int   wkAt     = 0;
  bit   abortArm = 0;
  int   abortAt  = 0;
  sbEntry_t sbQ[$];

  sleep_ctrl_if #(.CNT_W(CNT_W)) sif ();

  sleep_ctrl #(
    .CNT_W (CNT_W),
    .ACK_TO(ACK_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and update the counter model from the controls in force at that edge.
  task automatic tick();
    logic en, clr;
    en  = sif.cnt_en;
    clr = sif.cnt_clr;
    @(posedge clk);
    #1;
    cycle++;
    if (clr === 1'b1) cnt = 0;
    else if (en === 1'b1 && !(wkArm && cnt == wkAt)) cnt++;
    sif.cnt_val    = CNT_W'(cnt);
    sif.cnt_wakeup = wkArm && (cnt == wkAt);
    sif.abort      = abortArm && (cnt == abortAt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse (or hold) sleep_req for one accept edge.
  task automatic applyStimulus(input int cycles, input bit holdReq);
    sif.sleep_cycles = CNT_W'(cycles);
    sif.sleep_req    = 1'b1;
    tick();
    if (!holdReq) sif.sleep_req = 1'b0;
  endtask

  // Record the wake expected for a sleep accepted on the most recent edge.
  task automatic expectWake(input string tag, input logic [1:0] cause, input int latency);
    sbEntry_t e;
    e.tag         = tag;
    e.cause       = cause;
    e.latency     = latency;
    e.acceptCycle = cycle;
    sbQ.push_back(e);
  endtask

  // Wait (bounded) for irq, then compare it against the oldest expectation.
  task automatic waitIrq(input int budget);
    sbEntry_t e;
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (sif.irq === 1'b1) seen = 1;
    end
    checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    checkOutput({e.tag, "_irq_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({e.tag, "_latency"}, 32'(cycle - e.acceptCycle), 32'(e.latency));
      checkOutput({e.tag, "_cause"}, 32'(sif.wake_cause), 32'(e.cause));
    end
  endtask

  task automatic ackIrq(input string tag);
    sif.irq_ack = 1'b1;
    tick();
    sif.irq_ack = 1'b0;
    checkOutput({tag, "_ack_irq"}, 32'(sif.irq), 32'd0);
    checkOutput({tag, "_ack_busy"}, 32'(sif.busy), 32'd0);
    checkOutput({tag, "_ack_clr"}, 32'(sif.cnt_clr), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    rst_n            = 1'b0;
    sif.sleep_req    = 1'b0;
    sif.sleep_cycles = '0;
    sif.abort        = 1'b0;
    sif.cnt_val      = '0;
    sif.cnt_wakeup   = 1'b0;
    sif.irq_ack      = 1'b0;
    #1;

    $display("[TB] reset");
    ticks(4);
    checkOutput("rst_clr", 32'(sif.cnt_clr), 32'd1);
    checkOutput("rst_en", 32'(sif.cnt_en), 32'd0);
    checkOutput("rst_irq", 32'(sif.irq), 32'd0);
    checkOutput("rst_busy", 32'(sif.busy), 32'd0);
    checkOutput("rst_cause", 32'(sif.wake_cause), 32'd0);
    checkOutput("rst_wdog", 32'(sif.wdog_err), 32'd0);
    rst_n = 1'b1;
    ticks(2);

    $display("[TB] match wake, target 10");
    applyStimulus(10, 0);
    expectWake("match10", 2'b01, 13);
    checkOutput("m10_busy", 32'(sif.busy), 32'd1);
    tick();
    checkOutput("m10_arm_en", 32'(sif.cnt_en), 32'd0);
    checkOutput("m10_arm_clr", 32'(sif.cnt_clr), 32'd1);
    tick();
    checkOutput("m10_sleep_en", 32'(sif.cnt_en), 32'd1);
    checkOutput("m10_sleep_clr", 32'(sif.cnt_clr), 32'd0);
    waitIrq(40);
    checkOutput("m10_wake_en", 32'(sif.cnt_en), 32'd0);
    ackIrq("m10");

    $display("[TB] counter wakeup at 300");
    wkArm = 1;
    wkAt  = 300;
    applyStimulus(1000, 0);
    expectWake("wakeup300", 2'b10, 303);
    waitIrq(400);
    ticks(3);
    checkOutput("wk_hold_en", 32'(sif.cnt_en), 32'd0);
    checkOutput("wk_hold_clr", 32'(sif.cnt_clr), 32'd0);
    checkOutput("wk_hold_irq", 32'(sif.irq), 32'd1);
    ackIrq("wk");
    wkArm = 0;
    tick();

    $display("[TB] abort together with match");
    abortArm = 1;
    abortAt  = 5;
    applyStimulus(5, 0);
    expectWake("abort5", 2'b11, 8);
    waitIrq(40);
    abortArm  = 0;
    sif.abort = 1'b0;
    sif.sleep_cycles = CNT_W'(3);
    sif.sleep_req    = 1'b1;
    ticks(3);
    sif.sleep_req = 1'b0;
    checkOutput("ab_req_ign_irq", 32'(sif.irq), 32'd1);
    checkOutput("ab_req_ign_cause", 32'(sif.wake_cause), 32'd3);
    ackIrq("ab");
    tick();
    checkOutput("ab_stay_idle", 32'(sif.busy), 32'd0);

    $display("[TB] zero target");
    applyStimulus(0, 0);
    expectWake("zero", 2'b01, 2);
    waitIrq(20);
    ackIrq("zero");

    $display("[TB] back-to-back request");
    applyStimulus(2, 1);
    expectWake("b2b_first", 2'b01, 5);
    waitIrq(20);
    ackIrq("b2b");
    tick();
    checkOutput("b2b_rearm_busy", 32'(sif.busy), 32'd1);
    expectWake("b2b_second", 2'b01, 5);
    sif.sleep_req = 1'b0;
    waitIrq(20);
    ackIrq("b2b2");

    $display("[TB] reset mid-sleep");
    applyStimulus(100, 0);
    ticks(20);
    checkOutput("rs_sleep_en", 32'(sif.cnt_en), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rs_en", 32'(sif.cnt_en), 32'd0);
    checkOutput("rs_busy", 32'(sif.busy), 32'd0);
    checkOutput("rs_clr", 32'(sif.cnt_clr), 32'd1);
    ticks(5);
    checkOutput("rs_idle", 32'(sif.busy), 32'd0);

    $display("[TB] unacknowledged interrupt");
    applyStimulus(3, 0);
    expectWake("noack", 2'b01, 6);
    waitIrq(20);
`ifdef SLEEP_CTRL_WDOG_EN
    ticks(ACK_TO - 1);
    checkOutput("wd_before_irq", 32'(sif.irq), 32'd1);
    checkOutput("wd_before_err", 32'(sif.wdog_err), 32'd0);
    tick();
    checkOutput("wd_irq", 32'(sif.irq), 32'd0);
    checkOutput("wd_err", 32'(sif.wdog_err), 32'd1);
    checkOutput("wd_busy", 32'(sif.busy), 32'd0);
    ticks(5);
    checkOutput("wd_sticky", 32'(sif.wdog_err), 32'd1);
`else
    ticks(100);
    checkOutput("nowd_irq", 32'(sif.irq), 32'd1);
    checkOutput("nowd_err", 32'(sif.wdog_err), 32'd0);
    checkOutput("nowd_busy", 32'(sif.busy), 32'd1);
    ackIrq("nowd");
`endif

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
